neuron_mac: RTL and testbench
=============================

Name: neuron_mac

Overview:
- Per-neuron multiply-accumulate stage that sits directly downstream of the neuron's weight memory.
- Consumes one input sample per valid cycle and issues the matching read address/enable to the weight memory, which has one cycle of registered read latency.
- Multiplies each sample by the returned weight and accumulates a saturated signed sum plus bias over numWeight samples.
- Emits the pre-activation sum with a one-cycle valid pulse to the activation stage.

Parameters:
- numWeight, 784, samples (and weights) per frame; must be ≥2.
- dataWidth, 16, signed width of input samples and weights.
- addressWidth, 10, weight memory address width; 2^addressWidth ≥ numWeight.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  dataWidth  signed input sample.
- in_valid  in  1  in_data valid this cycle; no backpressure, every valid sample is accepted.
- bias  in  2*dataWidth  signed bias; held stable by the source and sampled at each frame's first product.
- w_ren  out  1  weight memory read enable.
- w_radd  out  addressWidth  weight memory read address.
- w_data  in  dataWidth  signed weight returned by memory one cycle after w_ren.
- out_data  out  2*dataWidth  signed saturated neuron sum.
- out_valid  out  1  one-cycle pulse when out_data is updated.
- busy  out  1  frame in progress or pipeline not drained.

Behaviour:
- Reset: clk and rst_n are the only clock/reset; reset is synchronous, active-low. While rst_n=0 at a clock edge, all of the following are cleared to 0: addr counter, pipeline valids, first/last tags, accumulator, out_data, out_valid.
- w_ren is combinational and equals in_valid.
- w_radd is the registered addr counter.
- Stage 0 (cycle T, in_valid=1):
  - addr increments, wrapping to 0 after numWeight-1.
  - Registered: in_data→x_d, valid→v1.
  - Tags registered with the sample: first=(addr==0), last=(addr==numWeight-1).
- Stage 1 (T+1): w_data is valid. Registered: prod=signed(x_d)*signed(w_data), full 2*dataWidth, no truncation; v2, first and last carried along.
- Stage 2 (T+2):
  - If v2: sum = (first ? bias : acc) + prod, computed with saturation.
  - Saturation: if both operands have the same sign and the result sign differs, clamp to 0x7FFF…F (positive) or 0x800…0 (negative).
  - acc<=sum.
  - If last: out_data<=sum, out_valid<=1, acc<=0.
- out_valid: high exactly one cycle. Latency is last valid sample at edge T → out_valid high in cycle T+3. out_data holds its value until the next frame completes.
- Gaps: in_valid may drop for any number of cycles mid-frame; the counter and accumulator hold.
- Back-to-back frames: the first sample of frame N+1 may arrive the cycle after the last sample of frame N. The first tag discards the old acc, so there are no bubbles and no cross-frame contamination.
- Saturation is sticky only through acc: later products may pull a clamped value back toward zero. This is intended behaviour, matching sequential saturating addition.
- busy = (addr!=0) | v1 | v2.
- Reset mid-frame: the partial sum is discarded, addr returns to 0, and no out_valid is produced for that frame. The next valid sample is treated as first.
- bias is not registered at frame start; the source guarantees stability from the first sample until first+2 cycles.

Test Plan:
1. numWeight=3, weights mem=[2,-3,4], inputs 5,6,7 back-to-back, bias=10 → w_radd 0,1,2; out_data=30 (10+10-18+28), out_valid exactly 3 cycles after the input of 7; busy low the cycle after.
2. Same frame with 2-cycle gaps between samples → identical out_data=30; w_ren high only on valid cycles; out_valid 3 cycles after the last sample.
3. Two frames back-to-back: inputs 5,6,7 then 1,1,1 (bias 10) → out_valid pulses give 30 then 13; no idle cycle needed between frames.
4. Positive saturation: weights 0x7FFF ×3, inputs 0x7FFF ×3, bias=0x7FFF0000 → out_data=0x7FFFFFFF.
5. Negative saturation: weights 0x8000, inputs 0x7FFF, bias=0x80000000 → out_data=0x80000000.
6. Reset mid-frame: 2 samples, then rst_n=0 for 1 cycle, then full frame 5,6,7 → single out_valid with out_data=30, w_radd restarts at 0, busy=0 during reset.

Source files
------------

// File: rtl/neuron_mac.sv
// Per-neuron multiply-accumulate: issues weight reads, multiplies each sample by its
// returned weight and accumulates a saturated signed sum plus bias over one frame.
module neuron_mac #(
    parameter int numWeight    = 784,
    parameter int dataWidth    = 16,
    parameter int addressWidth = 10
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic signed [dataWidth-1:0]     in_data,
    input  logic                            in_valid,
    input  logic signed [2*dataWidth-1:0]   bias,
    output logic                            w_ren,
    output logic [addressWidth-1:0]         w_radd,
    input  logic signed [dataWidth-1:0]     w_data,
    output logic signed [2*dataWidth-1:0]   out_data,
    output logic                            out_valid,
    output logic                            busy
);
    localparam int AccWidth = 2 * dataWidth;
    localparam logic [addressWidth-1:0] LastAddr = addressWidth'(numWeight - 1);
    localparam logic signed [AccWidth-1:0] SatPos = {1'b0, {(AccWidth-1){1'b1}}};
    localparam logic signed [AccWidth-1:0] SatNeg = {1'b1, {(AccWidth-1){1'b0}}};

    logic [addressWidth-1:0]      addr_q;
    logic signed [dataWidth-1:0]  x_q;
    logic                         v1_q, first1_q, last1_q;
    logic signed [AccWidth-1:0]   prod_q;
    logic                         v2_q, first2_q, last2_q;
    logic signed [AccWidth-1:0]   acc_q;
    logic signed [AccWidth-1:0]   out_data_q;
    logic                         out_valid_q;

    logic signed [AccWidth-1:0]   prod_d;
    logic signed [AccWidth-1:0]   base_d;
    logic signed [AccWidth-1:0]   sum_raw_d;
    logic signed [AccWidth-1:0]   sum_d;
    logic                         ovf_d;

    // Operands are sign-extended to the full width so the product is exact.
    assign prod_d    = AccWidth'(x_q) * AccWidth'(w_data);
    assign base_d    = first2_q ? bias : acc_q;
    assign sum_raw_d = base_d + prod_q;
    assign ovf_d     = (base_d[AccWidth-1] == prod_q[AccWidth-1]) &&
                       (sum_raw_d[AccWidth-1] != base_d[AccWidth-1]);
    assign sum_d     = ovf_d ? (base_d[AccWidth-1] ? SatNeg : SatPos) : sum_raw_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            x_q         <= '0;
            v1_q        <= 1'b0;
            first1_q    <= 1'b0;
            last1_q     <= 1'b0;
            prod_q      <= '0;
            v2_q        <= 1'b0;
            first2_q    <= 1'b0;
            last2_q     <= 1'b0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                x_q      <= in_data;
                first1_q <= (addr_q == '0);
                last1_q  <= (addr_q == LastAddr);
                addr_q   <= (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
            end

            v2_q <= v1_q;
            if (v1_q) begin
                prod_q   <= prod_d;
                first2_q <= first1_q;
                last2_q  <= last1_q;
            end

            out_valid_q <= 1'b0;
            if (v2_q) begin
                if (last2_q) begin
                    acc_q       <= '0;
                    out_data_q  <= sum_d;
                    out_valid_q <= 1'b1;
                end else begin
                    acc_q <= sum_d;
                end
            end
        end
    end

    assign w_ren     = in_valid;
    assign w_radd    = addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (addr_q != '0) | v1_q | v2_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with a 3-weight frame and a registered-read weight memory model.
module tb_neuron_mac;
    localparam int NW = 3;
    localparam int DW = 16;
    localparam int AW = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic signed [DW-1:0]   in_data = '0;
    logic                   in_valid = 1'b0;
    logic signed [2*DW-1:0] bias = '0;
    logic                   w_ren;
    logic [AW-1:0]          w_radd;
    logic signed [DW-1:0]   w_data = '0;
    logic signed [2*DW-1:0] out_data;
    logic                   out_valid;
    logic                   busy;

    logic signed [DW-1:0]   wmem [0:(1<<AW)-1];
    int                     cyc = 0;
    int                     n_cmp = 0;
    int                     n_bad = 0;
    logic [31:0]            outq [$];
    int                     stampq [$];

    neuron_mac #(.numWeight(NW), .dataWidth(DW), .addressWidth(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .bias(bias),
        .w_ren(w_ren), .w_radd(w_radd), .w_data(w_data),
        .out_data(out_data), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Weight memory with one cycle of registered read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (w_ren) w_data <= wmem[w_radd];
    end

    always @(negedge clk) begin
        if (out_valid) begin
            outq.push_back(out_data);
            stampq.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one sample, checking the read address issued with it; returns the edge count.
    task automatic send(input logic [DW-1:0] d, input int exp_addr, input string tag, output int edge_n);
        in_data  = d;
        in_valid = 1'b1;
        check({tag, " w_ren"}, {31'd0, w_ren}, 32'd1);
        check({tag, " w_radd"}, {30'd0, w_radd}, 32'(exp_addr));
        tick();
        edge_n   = cyc;
        in_valid = 1'b0;
    endtask

    task automatic set_w(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        wmem[0] = a; wmem[1] = b; wmem[2] = c; wmem[3] = '0;
    endtask

    // Checks that exactly one result arrived with the expected value and timing.
    task automatic expect_one(input string tag, input logic [31:0] exp, input int last_edge);
        check({tag, " pulses"}, 32'(outq.size()), 32'd1);
        if (outq.size() >= 1) begin
            check({tag, " out_data"}, outq[0], exp);
            check({tag, " latency"}, 32'(stampq[0] - last_edge), 32'd2);
        end
        outq.delete();
        stampq.delete();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int e;
        int e1;
        set_w(16'sd2, -16'sd3, 16'sd4);
        bias = 32'sd10;
        drain(2);
        check("reset out_data", out_data, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset w_radd", {30'd0, w_radd}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Test 1: back-to-back frame
        send(16'sd5, 0, "t1 s0", e);
        send(16'sd6, 1, "t1 s1", e);
        send(16'sd7, 2, "t1 s2", e);
        check("t1 busy in flight", {31'd0, busy}, 32'd1);
        tick();
        check("t1 out_valid early", {31'd0, out_valid}, 32'd0);
        tick();
        check("t1 out_valid", {31'd0, out_valid}, 32'd1);
        check("t1 busy drained", {31'd0, busy}, 32'd0);
        tick();
        check("t1 out_valid drop", {31'd0, out_valid}, 32'd0);
        check("t1 out_data hold", out_data, 32'd30);
        expect_one("t1", 32'd30, e);

        // Test 2: gaps between samples
        send(16'sd5, 0, "t2 s0", e);
        drain(2);
        check("t2 w_ren gap", {31'd0, w_ren}, 32'd0);
        check("t2 busy gap", {31'd0, busy}, 32'd1);
        send(16'sd6, 1, "t2 s1", e);
        drain(2);
        check("t2 w_radd hold", {30'd0, w_radd}, 32'd2);
        send(16'sd7, 2, "t2 s2", e);
        drain(5);
        expect_one("t2", 32'd30, e);

        // Test 3: two frames back-to-back
        send(16'sd5, 0, "t3 a0", e);
        send(16'sd6, 1, "t3 a1", e);
        send(16'sd7, 2, "t3 a2", e1);
        send(16'sd1, 0, "t3 b0", e);
        send(16'sd1, 1, "t3 b1", e);
        send(16'sd1, 2, "t3 b2", e);
        drain(5);
        check("t3 pulses", 32'(outq.size()), 32'd2);
        if (outq.size() == 2) begin
            check("t3 frame0", outq[0], 32'd30);
            check("t3 frame1", outq[1], 32'd13);
            check("t3 frame0 latency", 32'(stampq[0] - e1), 32'd2);
            check("t3 frame1 latency", 32'(stampq[1] - e), 32'd2);
        end
        outq.delete();
        stampq.delete();

        // Test 4: positive saturation
        set_w(16'h7FFF, 16'h7FFF, 16'h7FFF);
        bias = 32'h7FFF0000;
        for (int i = 0; i < NW; i++) send(16'h7FFF, i, "t4", e);
        drain(5);
        expect_one("t4", 32'h7FFFFFFF, e);

        // Test 5: negative saturation
        set_w(16'h8000, 16'h8000, 16'h8000);
        bias = 32'h80000000;
        for (int i = 0; i < NW; i++) send(16'h7FFF, i, "t5", e);
        drain(5);
        expect_one("t5", 32'h80000000, e);

        // Test 6: reset mid-frame
        set_w(16'sd2, -16'sd3, 16'sd4);
        bias = 32'sd10;
        send(16'sd9, 0, "t6 p0", e);
        send(16'sd9, 1, "t6 p1", e);
        rst_n = 1'b0;
        tick();
        check("t6 busy in reset", {31'd0, busy}, 32'd0);
        check("t6 w_radd in reset", {30'd0, w_radd}, 32'd0);
        rst_n = 1'b1;
        send(16'sd5, 0, "t6 s0", e);
        send(16'sd6, 1, "t6 s1", e);
        send(16'sd7, 2, "t6 s2", e);
        drain(5);
        expect_one("t6", 32'd30, e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule
